// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory-ready handshake and fetch timeout.
// Optional ori support (ORIEX state, zeroext port) is enabled by defining MIPS_ORI_EN.
module mips_multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       mem_err
`ifdef MIPS_ORI_EN
  ,output logic      zeroext
`endif
);

  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_ORIEX
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          timeout_s;

  // State and fetch-timeout counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Fetch timeout: counts stalled FETCH cycles, pulses on the last allowed one
  always_comb begin
    timeout_s = 1'b0;
    tcnt_d    = '0;
    if (state_q == S_FETCH && !mem_ready && FETCH_TIMEOUT != 0) begin
      if (tcnt_q == TMAX) begin
        timeout_s = 1'b1;
        tcnt_d    = '0;
      end else begin
        tcnt_d = tcnt_q + CW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // Next-state and Moore outputs; reset overrides strobes and selects last
  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    alucontrol = 3'b010;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
`ifdef MIPS_ORI_EN
    zeroext    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        mem_err = timeout_s;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RT:        state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS_ORI_EN
          OP_ORI:       state_d = S_ORIEX;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        state_d = S_RTYPEWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            alucontrol = 3'b010;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MIPS_ORI_EN
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b001;
        zeroext    = 1'b1;
        state_d    = S_ADDIWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      alucontrol = 3'b010;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
`ifdef MIPS_ORI_EN
      zeroext    = 1'b0;
`endif
    end else begin
      mem_err = mem_err & ~reset;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl (default build): instructions are expanded
// into per-cycle expected control words from the instruction-level rules, then replayed.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op, mem_err;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zr;
    logic [5:0]  o;
    logic [5:0]  f;
    logic [16:0] exp;
  } step_t;

  step_t q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .mem_err(mem_err)
  );

  // flags = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca}
  function automatic logic [16:0] cw(input logic [6:0] flags, input logic [1:0] asb,
                                     input logic [1:0] ps, input logic pe,
                                     input logic [2:0] alu, input logic ill, input logic me);
    return {flags, asb, ps, pe, alu, ill, me};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic zr,
                      input logic [5:0] o, input logic [5:0] f, input logic [16:0] e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.zr = zr; s.o = o; s.f = f; s.exp = e;
    q.push_back(s);
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b0, rb(), SW, 6'b000000, cw(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
  endtask

  // Expand one instruction: fw stalled fetch cycles, mw stalled memory cycles.
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic zb,
                       input int fw, input int mw);
    logic       legal, fok;
    logic [2:0] alu;
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'b0, rb(), o, f,
           cw(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0, ((i + 1) % 16) == 0));
    push(1'b0, 1'b1, rb(), o, f, cw(7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0));
    legal = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
    push(1'b0, rb(), rb(), o, f, cw(7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, !legal, 1'b0));
    if (o == LW || o == SW) begin
      push(1'b0, rb(), rb(), o, f, cw(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
      for (int i = 0; i <= mw; i++)
        push(1'b0, i == mw, rb(), o, f,
             cw({1'b1, o == SW, 5'b00000}, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
      if (o == LW)
        push(1'b0, rb(), rb(), o, f, cw(7'b0000110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    end else if (o == RT) begin
      fok = 1'b1;
      case (f)
        6'b100000: alu = 3'b010;
        6'b100010: alu = 3'b110;
        6'b100100: alu = 3'b000;
        6'b100101: alu = 3'b001;
        6'b101010: alu = 3'b111;
        default: begin alu = 3'b010; fok = 1'b0; end
      endcase
      push(1'b0, rb(), rb(), o, f, cw(7'b0000001, 2'b00, 2'b00, 1'b0, alu, !fok, 1'b0));
      push(1'b0, rb(), rb(), o, f, cw(7'b0001010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    end else if (o == BEQ) begin
      push(1'b0, rb(), zb, o, f, cw(7'b0000001, 2'b00, 2'b01, zb, 3'b110, 1'b0, 1'b0));
    end else if (o == ADDI) begin
      push(1'b0, rb(), rb(), o, f, cw(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
      push(1'b0, rb(), rb(), o, f, cw(7'b0000010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    end else if (o == JMP) begin
      push(1'b0, rb(), rb(), o, f, cw(7'b0000000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0));
    end else begin
      legal = 1'b0;
    end
  endtask

  initial begin
    logic [5:0]  rop, rfn;
    logic [16:0] obs;
    logic [5:0]  fns [6];
    int          k;
    int          pulses;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000111;

    push_reset(2);
    instr(LW, 6'b000000, 1'b0, 0, 0);
    instr(SW, 6'b000000, 1'b0, 0, 3);
    instr(RT, 6'b101010, 1'b0, 0, 0);
    instr(BEQ, 6'b000000, 1'b1, 0, 0);
    instr(BEQ, 6'b000000, 1'b0, 0, 0);
    instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    instr(6'b001101, 6'b000000, 1'b0, 0, 0);
    instr(JMP, 6'b000000, 1'b0, 1, 0);
    instr(ADDI, 6'b000000, 1'b0, 2, 0);
    instr(RT, 6'b000000, 1'b0, 0, 0);
    instr(LW, 6'b000000, 1'b0, 16, 2);
    instr(ADDI, 6'b000000, 1'b0, 33, 0);
    // sw stalled in MEMWR, then aborted by a two-cycle reset
    push(1'b0, 1'b1, 1'b0, SW, 6'b000000, cw(7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, SW, 6'b000000, cw(7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, SW, 6'b000000, cw(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, SW, 6'b000000, cw(7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, SW, 6'b000000, cw(7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0));
    push_reset(2);
    instr(JMP, 6'b000000, 1'b0, 3, 0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 7);
      rfn = fns[$urandom_range(0, 5)];
      case (k)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = BEQ;
        4: rop = ADDI;
        5: rop = JMP;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      instr(rop, rfn, rb(), $urandom_range(0, 20), $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) push_reset($urandom_range(1, 2));
    end

    reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; op = 6'b000000; funct = 6'b000000;
    @(posedge clk);
    #1;
    for (int i = 0; i < q.size(); i++) begin
      reset = q[i].rst; mem_ready = q[i].rdy; zero = q[i].zr; op = q[i].o; funct = q[i].f;
      #4;
      obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
             pcen, alucontrol, illegal_op, mem_err};
      total++;
      assert (obs === q[i].exp) else begin
        bad++;
        $error("FAIL step%0d op=%b funct=%b rst=%b rdy=%b observed=%b expected=%b",
               i, q[i].o, q[i].f, q[i].rst, q[i].rdy, obs, q[i].exp);
      end
      @(posedge clk);
      #1;
    end

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b1; op = SW; funct = 6'b000000;
    #4;
    obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
           pcen, alucontrol, illegal_op, mem_err};
    total++;
    if (obs !== cw(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0)) begin
      bad++;
      $error("FAIL reset-state observed=%b", obs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      #4;
      if (mem_err === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $error("FAIL fetch-timeout mem_err pulses=%0d expected=1", pulses);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
